// File: rtl/gpu_pkg.sv
//------------------------------------------------------------------------------
// gpu_pkg : shared types and constants for the GPU line/clear rasteriser.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DRAW  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } raster_state_t;

    localparam logic        GPU_OP_LINE  = 1'b0;
    localparam logic        GPU_OP_CLEAR = 1'b1;

    localparam logic [15:0] GPU_COLOR_BG = 16'h003f;
    localparam logic [15:0] GPU_COLOR_FG = 16'hffff;

endpackage

`default_nettype wire

// File: rtl/gpu_line_stepper.sv
//------------------------------------------------------------------------------
// gpu_line_stepper : all-octant Bresenham walker, one step per advance pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gpu_line_stepper
    import gpu_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_advance,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_last
);

    localparam int EW = COORD_W + 2;
    localparam logic signed [COORD_W:0] C_ONE = 1;

    logic signed [COORD_W:0] r_x, r_y;
    logic [COORD_W-1:0]      r_x1, r_y1;
    logic signed [EW-1:0]    r_err, r_dx, r_dy;
    logic                    r_sx_neg, r_sy_neg;

    logic signed [EW-1:0] w_x0e, w_y0e, w_x1e, w_y1e;
    logic signed [EW-1:0] w_dx_ld, w_dy_ld, w_e2, w_err_nxt;
    logic                 w_step_x, w_step_y;

    assign w_x0e = $signed({2'b00, i_x0});
    assign w_y0e = $signed({2'b00, i_y0});
    assign w_x1e = $signed({2'b00, i_x1});
    assign w_y1e = $signed({2'b00, i_y1});

    // dy is kept negative so a single signed error term covers every octant
    assign w_dx_ld = (i_x0 < i_x1) ? (w_x1e - w_x0e) : (w_x0e - w_x1e);
    assign w_dy_ld = (i_y0 < i_y1) ? (w_y0e - w_y1e) : (w_y1e - w_y0e);

    assign w_e2      = r_err <<< 1;
    assign w_step_x  = (w_e2 >= r_dy);
    assign w_step_y  = (w_e2 <= r_dx);
    assign w_err_nxt = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_err    <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else if (i_load) begin
            r_x      <= $signed({1'b0, i_x0});
            r_y      <= $signed({1'b0, i_y0});
            r_x1     <= i_x1;
            r_y1     <= i_y1;
            r_dx     <= w_dx_ld;
            r_dy     <= w_dy_ld;
            r_err    <= w_dx_ld + w_dy_ld;
            r_sx_neg <= !(i_x0 < i_x1);
            r_sy_neg <= !(i_y0 < i_y1);
        end else if (i_advance) begin
            r_err <= w_err_nxt;
            if (w_step_x)
                r_x <= r_sx_neg ? (r_x - C_ONE) : (r_x + C_ONE);
            if (w_step_y)
                r_y <= r_sy_neg ? (r_y - C_ONE) : (r_y + C_ONE);
        end
    end

    assign o_x    = r_x[COORD_W-1:0];
    assign o_y    = r_y[COORD_W-1:0];
    assign o_last = (r_x == $signed({1'b0, r_x1})) && (r_y == $signed({1'b0, r_y1}));

endmodule

`default_nettype wire

// File: rtl/gpu_line_raster.sv
//------------------------------------------------------------------------------
// gpu_line_raster : command-driven line / full-screen clear rasteriser onto the
// GPU-SRAM write port. Optional macro GPU_RASTER_CLIP_EN suppresses off-screen
// line pixels.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gpu_line_raster
    import gpu_pkg::*;
#(
    parameter int H_RES   = 640,
    parameter int V_RES   = 400,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic               I_VIDEO_ON,
    input  logic               I_CMD_VALID,
    output logic               O_CMD_READY,
    input  logic               I_CMD_OP,
    input  logic [COORD_W-1:0] I_X0,
    input  logic [COORD_W-1:0] I_Y0,
    input  logic [COORD_W-1:0] I_X1,
    input  logic [COORD_W-1:0] I_Y1,
    input  logic [DATA_W-1:0]  I_COLOR,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [DATA_W-1:0]  O_GPU_DATA,
    output logic               O_GPU_WRITE,
    output logic               O_GPU_READ,
    output logic               O_BUSY,
    output logic               O_DONE
);

    raster_state_t r_state, w_state_next;

    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [DATA_W-1:0]  r_color;
    logic [COORD_W-1:0] r_cx, r_cy;

    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_write, r_read, r_ready, r_busy, r_done;

    logic               w_hs, w_load, w_advance, w_pix_write, w_in_range;
    logic               w_last, w_clear_end;
    logic [COORD_W-1:0] w_step_x, w_step_y, w_pix_x, w_pix_y;
    logic [ADDR_W-1:0]  w_addr;

    gpu_line_stepper #(
        .COORD_W (COORD_W)
    ) u_stepper (
        .i_clk     (I_CLK),
        .i_rst_n   (I_RST_N),
        .i_load    (w_load),
        .i_advance (w_advance),
        .i_x0      (r_x0),
        .i_y0      (r_y0),
        .i_x1      (r_x1),
        .i_y1      (r_y1),
        .o_x       (w_step_x),
        .o_y       (w_step_y),
        .o_last    (w_last)
    );

`ifdef GPU_RASTER_CLIP_EN
    assign w_in_range = (32'(w_step_x) < H_RES) && (32'(w_step_y) < V_RES);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_hs        = I_CMD_VALID && r_ready && (r_state == ST_IDLE);
    assign w_clear_end = (r_cx == COORD_W'(H_RES - 1)) && (r_cy == COORD_W'(V_RES - 1));
    assign w_addr      = ADDR_W'(w_pix_y) * ADDR_W'(H_RES) + ADDR_W'(w_pix_x);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_pix_write  = 1'b0;
        w_pix_x      = w_step_x;
        w_pix_y      = w_step_y;
        case (r_state)
            ST_IDLE: begin
                if (w_hs)
                    w_state_next = (I_CMD_OP == GPU_OP_CLEAR) ? ST_CLEAR : ST_SETUP;
            end
            ST_SETUP: begin
                w_load       = 1'b1;
                w_state_next = ST_DRAW;
            end
            ST_DRAW: begin
                if (!I_VIDEO_ON) begin
                    w_pix_write = w_in_range;
                    if (w_last)
                        w_state_next = ST_DONE;
                    else
                        w_advance = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_pix_x = r_cx;
                w_pix_y = r_cy;
                if (!I_VIDEO_ON) begin
                    w_pix_write = 1'b1;
                    if (w_clear_end)
                        w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_color <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else if (w_hs) begin
            r_x0    <= I_X0;
            r_y0    <= I_Y0;
            r_x1    <= I_X1;
            r_y1    <= I_Y1;
            r_color <= I_COLOR;
            r_cx    <= '0;
            r_cy    <= '0;
        end else if ((r_state == ST_CLEAR) && !I_VIDEO_ON) begin
            if (r_cx == COORD_W'(H_RES - 1)) begin
                r_cx <= '0;
                r_cy <= r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    // Ready returns one cycle after the DONE pulse, which itself trails the last write
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
            r_read  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_write <= w_pix_write;
            r_read  <= 1'b0;
            r_ready <= (r_state == ST_IDLE) && !w_hs;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (r_state == ST_DONE);
            if (w_pix_write) begin
                r_addr <= w_addr;
                r_data <= r_color;
            end
        end
    end

    assign O_GPU_ADDR  = r_addr;
    assign O_GPU_DATA  = r_data;
    assign O_GPU_WRITE = r_write;
    assign O_GPU_READ  = r_read;
    assign O_CMD_READY = r_ready;
    assign O_BUSY      = r_busy;
    assign O_DONE      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_gpu_line_raster.sv
//------------------------------------------------------------------------------
// tb_gpu_line_raster : randomized self-checking bench for gpu_line_raster,
// using a reduced frame so a full clear stays short.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_gpu_line_raster;

    localparam int H  = 64;
    localparam int V  = 40;
    localparam int CW = 10;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          video_on = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_op = 1'b0;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [DW-1:0] color = '0;
    logic          cmd_ready, gpu_write, gpu_read, busy, done;
    logic [AW-1:0] gpu_addr;
    logic [DW-1:0] gpu_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int vmode = 0;
    int vcnt  = 0;

    int q_addr[$];
    int q_data[$];
    int q_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int vid_viol = 0;
    int read_bad = 0;

    int exp_addr[$];

    gpu_line_raster #(
        .H_RES(H), .V_RES(V), .COORD_W(CW), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .I_CLK       (clk),
        .I_RST_N     (rst_n),
        .I_VIDEO_ON  (video_on),
        .I_CMD_VALID (cmd_valid),
        .O_CMD_READY (cmd_ready),
        .I_CMD_OP    (cmd_op),
        .I_X0        (x0),
        .I_Y0        (y0),
        .I_X1        (x1),
        .I_Y1        (y1),
        .I_COLOR     (color),
        .O_GPU_ADDR  (gpu_addr),
        .O_GPU_DATA  (gpu_data),
        .O_GPU_WRITE (gpu_write),
        .O_GPU_READ  (gpu_read),
        .O_BUSY      (busy),
        .O_DONE      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Video-on driver: 0 = off, 1 = random, 2 = toggle every 100 cycles
    initial forever begin
        @(negedge clk);
        if (vmode == 0) begin
            video_on = 1'b0;
        end else if (vmode == 1) begin
            video_on = ($urandom_range(3, 0) == 0);
        end else begin
            vcnt = vcnt + 1;
            if (vcnt >= 100) begin
                vcnt = 0;
                video_on = ~video_on;
            end
        end
    end

    // Write/done monitor sampled 1 time unit after each rising edge
    initial forever begin
        logic v;
        @(posedge clk);
        v = video_on;
        #1;
        if (gpu_write === 1'b1) begin
            q_addr.push_back(int'(gpu_addr));
            q_data.push_back(int'(gpu_data));
            q_cyc.push_back(cyc);
            if (v) vid_viol++;
        end
        if (gpu_read !== 1'b0) read_bad++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clr_mon();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        done_cnt = 0;
        vid_viol = 0;
    endtask

    // Reference: plain integer Bresenham over the frame address map
    task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, x, y, n;
        exp_addr.delete();
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        n   = 0;
        while (n < 4096) begin
            n++;
`ifdef GPU_RASTER_CLIP_EN
            if (x < H && y < V) exp_addr.push_back((y * H + x) % (1 << AW));
`else
            exp_addr.push_back((y * H + x) % (1 << AW));
`endif
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic send_cmd(input logic op, input int ax0, input int ay0, input int ax1,
                            input int ay1, input logic [DW-1:0] col, output int hs);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout: ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        color = col;
        @(posedge clk);
        #1;
        hs = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL done_timeout: done pulses=%0d required %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (gpu_addr !== '0 || gpu_data !== '0 || gpu_write !== 1'b0 || gpu_read !== 1'b0 ||
            cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: addr=%0d data=%0h wr=%b rd=%b rdy=%b busy=%b done=%b required 0 0 0 0 1 0 0",
                     gpu_addr, gpu_data, gpu_write, gpu_read, cmd_ready, busy, done);
        end
    endtask

    task automatic test_line(input int ax0, input int ay0, input int ax1, input int ay1,
                             input logic [DW-1:0] col);
        int hs, n_exp, adx, ady;
        adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        n_exp = ((adx > ady) ? adx : ady) + 1;
        model_line(ax0, ay0, ax1, ay1);
        vmode = 0;
        clr_mon();
        send_cmd(1'b0, ax0, ay0, ax1, ay1, col, hs);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL line_hs_flags: busy=%b ready=%b required 1 0", busy, cmd_ready);
        end
        wait_done(1, n_exp * 2 + 50);
        checks++;
        if (q_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL line_count (%0d,%0d)->(%0d,%0d): writes=%0d required %0d",
                     ax0, ay0, ax1, ay1, q_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (q_addr[i] != exp_addr[i] || q_data[i] != int'(col)) begin
                    errors++;
                    $display("FAIL line_pixel[%0d]: addr=%0d data=%0h required addr=%0d data=%0h",
                             i, q_addr[i], q_data[i], exp_addr[i], col);
                end
            end
        end
`ifndef GPU_RASTER_CLIP_EN
        checks++;
        if (q_addr.size() != n_exp) begin
            errors++;
            $display("FAIL line_len_formula: writes=%0d required %0d", q_addr.size(), n_exp);
        end
`endif
        checks++;
        if (done_cyc != hs + n_exp + 2) begin
            errors++;
            $display("FAIL line_done_timing: done at +%0d required +%0d", done_cyc - hs, n_exp + 2);
        end
        if (q_cyc.size() > 0) begin
            checks++;
            if (q_cyc[0] != hs + 2) begin
                errors++;
                $display("FAIL line_first_write: at +%0d required +2", q_cyc[0] - hs);
            end
            if (exp_addr.size() == n_exp) begin
                checks++;
                if (q_cyc[q_cyc.size()-1] != done_cyc - 1) begin
                    errors++;
                    $display("FAIL line_last_write: at %0d required %0d",
                             q_cyc[q_cyc.size()-1], done_cyc - 1);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL line_done_flags: busy=%b done=%b ready=%b required 0 1 0", busy, done, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL line_ready_return: ready=%b done=%b required 1 0", cmd_ready, done);
        end
    endtask

    task automatic test_random_lines();
        for (int k = 0; k < 16; k++)
            test_line($urandom_range(H - 1, 0), $urandom_range(V - 1, 0),
                      $urandom_range(H - 1, 0), $urandom_range(V - 1, 0), DW'($urandom));
    endtask

    task automatic test_stall();
        int hs, ax0, ay0, ax1, ay1;
        for (int k = 0; k < 6; k++) begin
            ax0 = $urandom_range(H - 1, 0); ay0 = $urandom_range(V - 1, 0);
            ax1 = $urandom_range(H - 1, 0); ay1 = $urandom_range(V - 1, 0);
            model_line(ax0, ay0, ax1, ay1);
            clr_mon();
            vmode = 1;
            send_cmd(1'b0, ax0, ay0, ax1, ay1, 16'h1234, hs);
            wait_done(1, 1000);
            vmode = 0;
            checks++;
            if (q_addr != exp_addr || vid_viol != 0) begin
                errors++;
                $display("FAIL stall_line[%0d]: writes=%0d viol=%0d required writes=%0d viol=0",
                         k, q_addr.size(), vid_viol, exp_addr.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        int hs1, hs2, ax0, ax1, n1;
        ax0 = $urandom_range(20, 0);
        ax1 = ax0 + $urandom_range(30, 1);
        n1  = ax1 - ax0 + 1;
        vmode = 0;
        clr_mon();
        send_cmd(1'b0, ax0, 5, ax1, 5, 16'haaaa, hs1);
        send_cmd(1'b0, 3, 1, 3, 9, 16'h5555, hs2);
        wait_done(2, 200);
        checks++;
        if (hs2 - hs1 != n1 + 4) begin
            errors++;
            $display("FAIL b2b_period: %0d cycles required %0d", hs2 - hs1, n1 + 4);
        end
        checks++;
        if (q_addr.size() != n1 + 9 || q_addr[n1] != 1 * H + 3 || q_data[n1] != 16'h5555) begin
            errors++;
            $display("FAIL b2b_writes: count=%0d required %0d", q_addr.size(), n1 + 9);
        end
    endtask

    task automatic test_clear();
        int hs, bad;
        clr_mon();
        vcnt  = 0;
        vmode = 2;
        send_cmd(1'b1, 0, 0, 0, 0, 16'h003f, hs);
        wait_done(1, 3 * H * V + 500);
        vmode = 0;
        bad = 0;
        foreach (q_addr[i])
            if (q_addr[i] != i || q_data[i] != 16'h003f) bad++;
        checks++;
        if (q_addr.size() != H * V || bad != 0) begin
            errors++;
            $display("FAIL clear_writes: count=%0d badpix=%0d required %0d 0", q_addr.size(), bad, H * V);
        end
        checks++;
        if (q_addr.size() == 0 || q_addr[q_addr.size()-1] != H * V - 1) begin
            errors++;
            $display("FAIL clear_last_addr: size=%0d required last %0d", q_addr.size(), H * V - 1);
        end
        checks++;
        if (vid_viol != 0) begin
            errors++;
            $display("FAIL clear_video_on: writes during video=%0d required 0", vid_viol);
        end
        clr_mon();
        send_cmd(1'b1, 0, 0, 0, 0, 16'h0f0f, hs);
        wait_done(1, H * V + 50);
        checks++;
        if (q_cyc.size() == 0 || q_cyc[0] != hs + 1 || done_cyc != hs + H * V + 1) begin
            errors++;
            $display("FAIL clear_timing: done at +%0d required +%0d", done_cyc - hs, H * V + 1);
        end
    endtask

    task automatic test_reset_mid();
        int hs, n = 0;
        clr_mon();
        send_cmd(1'b0, 0, 2, 9, 2, 16'hbeef, hs);
        while (q_addr.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags: ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (q_addr.size() != 3 || done_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_writes: writes=%0d done=%0d required 3 0", q_addr.size(), done_cnt);
        end
    endtask

    task automatic test_clip();
        // Runs off the right edge; clipped builds keep only x<H
        test_line(H - 4, 0, H + 3, 0, 16'hffff);
        checks++;
`ifdef GPU_RASTER_CLIP_EN
        if (q_addr.size() != 4) begin
            errors++;
            $display("FAIL clip_count: writes=%0d required 4", q_addr.size());
        end
`else
        if (q_addr.size() != 8) begin
            errors++;
            $display("FAIL noclip_count: writes=%0d required 8", q_addr.size());
        end
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_line(2, 3, 6, 3, 16'hffff);
        test_line(10, 20, 7, 12, 16'h00ff);
        test_line(5, 5, 5, 5, 16'h7777);
        test_line(0, 0, H - 1, V - 1, 16'h0101);
        test_random_lines();
        test_stall();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_clip();
        checks++;
        if (read_bad != 0) begin
            errors++;
            $display("FAIL read_strobe: cycles with read!=0 = %0d required 0", read_bad);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpu_line_raster.md
# gpu_line_raster

Parametrised line/clear rasteriser for the GPU-SRAM frame-buffer path. It accepts drawing commands over a valid/ready handshake and walks an all-octant Bresenham line, or a full-screen clear, one pixel per cycle. Each pixel becomes a single write on the GPU-SRAM port, issued only while `I_VIDEO_ON` is low. It replaces fixed-geometry, fixed-slope drawing with runtime coordinates, colour and opcode.

## Interface
- `H_RES`, 640, frame width in pixels; address = y*H_RES + x
- `V_RES`, 400, frame height in pixels
- `COORD_W`, 10, coordinate width
- `ADDR_W`, 18, SRAM address width
- `DATA_W`, 16, pixel/colour width

Ports (reset: I_RST_N, asynchronous, active-low; clock I_CLK):
- `I_CLK`  in  1  clock
- `I_RST_N`  in  1  asynchronous active-low reset
- `I_VIDEO_ON`  in  1  high = display owns SRAM; block must not write
- `I_CMD_VALID`  in  1  command present
- `O_CMD_READY`  out  1  block can accept a command
- `I_CMD_OP`  in  1  0 = LINE, 1 = CLEAR
- `I_X0`, `I_Y0`, `I_X1`, `I_Y1`  in  COORD_W each  line endpoints (unsigned)
- `I_COLOR`  in  DATA_W  pixel value
- `O_GPU_ADDR`  out  ADDR_W  write address
- `O_GPU_DATA`  out  DATA_W  write data
- `O_GPU_WRITE`  out  1  write strobe, one pixel per asserted cycle
- `O_GPU_READ`  out  1  tied low (registered 0)
- `O_BUSY`  out  1  command in progress
- `O_DONE`  out  1  one-cycle pulse when command completes

## Operation
- States: IDLE, SETUP, DRAW, CLEAR, DONE.
- IDLE: `O_CMD_READY`=1. Handshake fires when `I_CMD_VALID && O_CMD_READY`. Operands, colour and opcode are latched. LINE goes to SETUP; CLEAR goes to CLEAR with x=y=0.
- SETUP (1 cycle) computes:
  - dx=|x1-x0|, dy=-|y1-y0|
  - sx=(x0<x1)?+1:-1, sy=(y0<y1)?+1:-1
  - err=dx+dy, x=x0, y=y0
  - then go to DRAW.
- DRAW, per cycle with `I_VIDEO_ON`=0:
  - Write (x,y).
  - If x==x1 && y==y1, go to DONE.
  - Otherwise e2=2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both updates may happen in the same cycle (diagonal step).
- CLEAR: raster x 0..H_RES-1, then y 0..V_RES-1, one write per cycle. After (H_RES-1, V_RES-1) is written, go to DONE.
- Video-on stall: `I_VIDEO_ON`=1 in DRAW/CLEAR means no write and all stepping registers hold. Resume on the cycle it drops.
- DONE (1 cycle): `O_DONE`=1, then IDLE.
- A LINE command writes exactly max(dx,|dy|)+1 pixels. The start pixel is always written first and the end pixel last. x0==x1 && y0==y1 writes exactly one pixel.
- Arithmetic: err and e2 are signed, COORD_W+2 bits; x and y are COORD_W+1 signed internally. Address multiply is done at ADDR_W width, truncating.
- Reset mid-operation: returns to IDLE immediately. Any in-progress line is abandoned with no further writes.

## Timing
- Reset values: `O_GPU_ADDR`=0, `O_GPU_DATA`=0, `O_GPU_WRITE`=0, `O_GPU_READ`=0, `O_CMD_READY`=1, `O_BUSY`=0, `O_DONE`=0, state=IDLE.
- All outputs are registered.
- `O_CMD_READY` drops the cycle after the handshake. `O_BUSY` rises the same cycle.
- LINE: first `O_GPU_WRITE` is 2 cycles after the handshake (SETUP, then the first DRAW edge), assuming no stall.
- CLEAR: first write is 1 cycle after the handshake.
- `O_DONE` pulses the cycle after the last write. `O_BUSY` falls with `O_DONE`. `O_CMD_READY` rises the cycle after `O_DONE`.
- Minimum LINE command period, handshake to next handshake: N+4 cycles (no stall).
- `O_GPU_ADDR` and `O_GPU_DATA` are valid whenever `O_GPU_WRITE`=1; otherwise they hold their last value.

## Configuration
- `GPU_RASTER_CLIP_EN` defined:
  - Pixels with x>=H_RES or y>=V_RES are stepped through but not written (`O_GPU_WRITE`=0 that cycle).
  - Cycle count is unchanged.
- Undefined:
  - Every stepped pixel is written, with the address truncated to ADDR_W (wraps).
  - Callers must supply in-range coordinates.

## Structure
- Package `gpu_pkg` holds:
  - state enum `raster_state_t`
  - opcode constants `GPU_OP_LINE`=0 and `GPU_OP_CLEAR`=1
  - default colour constants `GPU_COLOR_BG`=16'h003f and `GPU_COLOR_FG`=16'hffff
- One sub-module, `gpu_line_stepper`:
  - holds x, y, err, dx, dy, sx, sy
  - inputs: load and advance
  - outputs: current x/y and `last`
- The top module owns the FSM, handshake, clear counter, address generation and clipping.

## Test plan
- LINE (2,3)->(6,3), colour 16'hffff: 5 writes, addresses 1922..1926 in order; DONE pulse 1 cycle after the last write.
- LINE (10,20)->(7,12), steep negative: 9 writes; first address 12810, last 7687; each write moves y by -1.
- LINE (5,5)->(5,5): exactly one write at address 3205; `O_DONE` one cycle later.
- CLEAR with colour 16'h003f and `I_VIDEO_ON` toggling every 100 cycles:
  - exactly 256000 writes, no write while `I_VIDEO_ON`=1
  - last address 255999
- Reset asserted after 3 writes of a 10-pixel line: no further writes; after release, `O_CMD_READY`=1 and `O_BUSY`=0.
- With `GPU_RASTER_CLIP_EN`, LINE (636,0)->(643,0): only 4 writes (x=636..639), completion timing identical to an unclipped 8-pixel line.
